// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: RISC-V MEM stage driving a single-outstanding req/ack data bus.
// Define MEM_MISALIGN_TRAP_EN to replace misaligned accesses with a misalign_o pulse.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 5
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 5
`endif

module mem_stage_lsu (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [`ALU_OP_WIDTH-1:0] AluOP_i,
  input  logic [31:0]              mem_addr_i,
  input  logic [`DATA_WIDTH-1:0]   mem_wdata_i,
  input  logic [`REG_WIDTH-1:0]    rd_i,
  input  logic                     rd_op_i,
  input  logic [`DATA_WIDTH-1:0]   rd_data_i,
  output logic [`REG_WIDTH-1:0]    rd_o,
  output logic                     rd_op_o,
  output logic [`DATA_WIDTH-1:0]   rd_data_o,
  output logic                     stallreq,
  output logic                     dbus_req,
  output logic                     dbus_we,
  output logic [31:0]              dbus_addr,
  output logic [3:0]               dbus_be,
  output logic [`DATA_WIDTH-1:0]   dbus_wdata,
  input  logic                     dbus_ack,
  input  logic [`DATA_WIDTH-1:0]   dbus_rdata,
  output logic                     misalign_o
);

  localparam int AW = `ALU_OP_WIDTH;
  localparam logic [AW-1:0] OP_LB  = AW'(16);
  localparam logic [AW-1:0] OP_LH  = AW'(17);
  localparam logic [AW-1:0] OP_LW  = AW'(18);
  localparam logic [AW-1:0] OP_LBU = AW'(19);
  localparam logic [AW-1:0] OP_LHU = AW'(20);
  localparam logic [AW-1:0] OP_SB  = AW'(21);
  localparam logic [AW-1:0] OP_SH  = AW'(22);
  localparam logic [AW-1:0] OP_SW  = AW'(23);

  typedef enum logic {IDLE, REQ} state_t;
  state_t state, state_nxt;

  logic [AW-1:0]            op_p1;
  logic [31:0]              addr_p1;
  logic [`DATA_WIDTH-1:0]   wdata_p1;
  logic [`REG_WIDTH-1:0]    rd_p1;
  logic                     rd_op_p1;
  logic                     mis_i;

  function automatic logic is_load(input logic [AW-1:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load = 1'b1;
      default:                             is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [AW-1:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW: is_store = 1'b1;
      default:             is_store = 1'b0;
    endcase
  endfunction

  function automatic logic is_mem(input logic [AW-1:0] op);
    is_mem = is_load(op) || is_store(op);
  endfunction

  // 0 = byte, 1 = half, 2 = word
  function automatic logic [1:0] acc_size(input logic [AW-1:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: acc_size = 2'd0;
      OP_LH, OP_LHU, OP_SH: acc_size = 2'd1;
      default:              acc_size = 2'd2;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [AW-1:0] op, input logic [1:0] lo);
    case (acc_size(op))
      2'd0:    lane_be = 4'b0001 << lo;
      2'd1:    lane_be = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [AW-1:0] op, input logic [31:0] w);
    case (acc_size(op))
      2'd0:    lane_wdata = {4{w[7:0]}};
      2'd1:    lane_wdata = {2{w[15:0]}};
      default: lane_wdata = w;
    endcase
  endfunction

  function automatic logic [31:0] fmt_load(input logic [AW-1:0] op, input logic [1:0] lo,
                                           input logic [31:0] rdata);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] s;
    case (lo)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lo[1] ? rdata[31:16] : rdata[15:0];
    s = 32'sd0;
    case (op)
      OP_LB:   begin s = b; fmt_load = s; end
      OP_LBU:  fmt_load = {24'd0, b};
      OP_LH:   begin s = h; fmt_load = s; end
      OP_LHU:  fmt_load = {16'd0, h};
      default: fmt_load = rdata;
    endcase
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [AW-1:0] op, input logic [1:0] lo);
    if (!is_mem(op))
      misaligned = 1'b0;
    else begin
      case (acc_size(op))
        2'd0:    misaligned = 1'b0;
        2'd1:    misaligned = lo[0];
        default: misaligned = (lo != 2'b00);
      endcase
    end
  endfunction

  logic misalign_q;
  assign mis_i = misaligned(AluOP_i, mem_addr_i[1:0]);

  always_ff @(posedge CLK) begin
    if (RST) misalign_q <= 1'b0;
    else     misalign_q <= (state == IDLE) && mis_i;
  end
  assign misalign_o = misalign_q;
`else
  assign mis_i      = 1'b0;
  assign misalign_o = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (is_mem(AluOP_i) && !mis_i) state_nxt = REQ;
      REQ:     if (dbus_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stallreq = 1'b0;
    dbus_req = 1'b0;
    dbus_we  = 1'b0;
    dbus_be  = 4'b0000;
    case (state)
      IDLE: stallreq = is_mem(AluOP_i) && !mis_i;
      REQ: begin
        dbus_req = 1'b1;
        dbus_we  = is_store(op_p1);
        dbus_be  = lane_be(op_p1, addr_p1[1:0]);
        stallreq = !dbus_ack;
      end
      default: ;
    endcase
    if (RST) stallreq = 1'b0;
  end

  assign dbus_addr  = {addr_p1[31:2], 2'b00};
  assign dbus_wdata = lane_wdata(op_p1, wdata_p1);

  // p1: copy of the memory op held stable for the whole bus access
  always_ff @(posedge CLK) begin
    if (state == IDLE && is_mem(AluOP_i)) begin
      op_p1    <= AluOP_i;
      addr_p1  <= mem_addr_i;
      wdata_p1 <= mem_wdata_i;
      rd_p1    <= rd_i;
      rd_op_p1 <= rd_op_i;
    end
  end

  // writeback register: pass-through in IDLE, retirement on ack in REQ
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_o      <= '0;
      rd_op_o   <= 1'b0;
      rd_data_o <= '0;
    end else begin
      rd_op_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!is_mem(AluOP_i)) begin
            rd_o      <= rd_i;
            rd_op_o   <= rd_op_i;
            rd_data_o <= rd_data_i;
          end
        end
        REQ: begin
          if (dbus_ack) begin
            rd_o <= rd_p1;
            if (is_load(op_p1)) begin
              rd_op_o   <= rd_op_p1;
              rd_data_o <= fmt_load(op_p1, addr_p1[1:0], dbus_rdata);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: stimulus queues expectations, monitors compare.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 5
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 5
`endif

module tb_mem_stage_lsu;
  localparam int AW = `ALU_OP_WIDTH;
  localparam int RW = `REG_WIDTH;
  localparam logic [AW-1:0] OP_ADD = AW'(0);
  localparam logic [AW-1:0] OP_LB  = AW'(16);
  localparam logic [AW-1:0] OP_LH  = AW'(17);
  localparam logic [AW-1:0] OP_LW  = AW'(18);
  localparam logic [AW-1:0] OP_LBU = AW'(19);
  localparam logic [AW-1:0] OP_LHU = AW'(20);
  localparam logic [AW-1:0] OP_SB  = AW'(21);
  localparam logic [AW-1:0] OP_SH  = AW'(22);
  localparam logic [AW-1:0] OP_SW  = AW'(23);

  logic          CLK, RST;
  logic [AW-1:0] AluOP_i;
  logic [31:0]   mem_addr_i, mem_wdata_i, rd_data_i;
  logic [RW-1:0] rd_i;
  logic          rd_op_i;
  logic [RW-1:0] rd_o;
  logic          rd_op_o;
  logic [31:0]   rd_data_o;
  logic          stallreq, dbus_req, dbus_we, dbus_ack, misalign_o;
  logic [31:0]   dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]    dbus_be;

  mem_stage_lsu dut (
    .CLK(CLK), .RST(RST), .AluOP_i(AluOP_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .rd_i(rd_i), .rd_op_i(rd_op_i), .rd_data_i(rd_data_i),
    .rd_o(rd_o), .rd_op_o(rd_op_o), .rd_data_o(rd_data_o), .stallreq(stallreq),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .misalign_o(misalign_o)
  );

  typedef struct { logic [RW-1:0] rd; logic [31:0] data; } wb_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } bus_t;
  wb_t  wb_q[$];
  bus_t bus_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int req_rises = 0;
  logic prev_req = 1'b0;
  int ack_delay = 0;
  logic [31:0] rdata_val = 32'h0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_wb(input logic [RW-1:0] rd, input logic [31:0] data);
    wb_t e;
    e.rd = rd; e.data = data;
    wb_q.push_back(e);
  endtask

  task automatic push_bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata);
    bus_t e;
    e.we = we; e.addr = addr; e.be = be; e.wdata = wdata;
    bus_q.push_back(e);
  endtask

  task automatic drive_nop();
    AluOP_i = OP_ADD; mem_addr_i = 32'h0; mem_wdata_i = 32'h0;
    rd_i = '0; rd_op_i = 1'b0; rd_data_i = 32'h0;
  endtask

  // Call at posedge+2; returns at posedge+2 of the cycle after the op was accepted.
  task automatic issue(input logic [AW-1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [RW-1:0] rd, input logic rdop, input logic [31:0] rdat,
                       output int stalls);
    int cyc;
    logic s;
    AluOP_i = op; mem_addr_i = addr; mem_wdata_i = wdata;
    rd_i = rd; rd_op_i = rdop; rd_data_i = rdat;
    stalls = 0; cyc = 0;
    forever begin
      @(negedge CLK);
      s = stallreq;
      if (s) stalls++;
      @(posedge CLK);
      if (!s) break;
      cyc++;
      if (cyc >= 50) begin
        check("issue_timeout", cyc, 0);
        break;
      end
    end
    #2;
    drive_nop();
  endtask

  // Bus slave: acks after ack_delay wait cycles of an active request.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    dbus_ack = 1'b0;
    dbus_rdata = 32'h0;
    forever begin
      @(posedge CLK);
      #1;
      if (dbus_req === 1'b1) begin
        if (wait_cnt >= ack_delay) begin
          dbus_ack = 1'b1;
          dbus_rdata = rdata_val;
        end else begin
          dbus_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        dbus_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  initial begin
    wb_t  w;
    bus_t b;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (rd_op_o === 1'b1) begin
          if (wb_q.size() == 0) check("wb_unexpected", rd_op_o, 0);
          else begin
            w = wb_q.pop_front();
            check("wb_rd", rd_o, w.rd);
            check("wb_data", rd_data_o, w.data);
          end
        end
        if (dbus_req === 1'b1) begin
          if (!prev_req) req_rises++;
          if (bus_q.size() == 0) check("bus_unexpected", dbus_req, 0);
          else begin
            b = bus_q[0];
            check("bus_we", dbus_we, b.we);
            check("bus_addr", dbus_addr, b.addr);
            check("bus_be", dbus_be, b.be);
            if (b.we) check("bus_wdata", dbus_wdata, b.wdata);
            if (dbus_ack) void'(bus_q.pop_front());
          end
        end
      end
      prev_req = dbus_req;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int st, rises0;
    RST = 1'b1;
    AluOP_i = OP_LW; mem_addr_i = 32'h10; mem_wdata_i = 32'h0;
    rd_i = RW'(1); rd_op_i = 1'b1; rd_data_i = 32'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_stallreq", stallreq, 0);
    check("rst_rd_o", rd_o, 0);
    check("rst_rd_op_o", rd_op_o, 0);
    check("rst_rd_data_o", rd_data_o, 0);
    check("rst_misalign", misalign_o, 0);
    check("rst_req", dbus_req, 0);
    check("rst_we", dbus_we, 0);
    check("rst_be", dbus_be, 0);
    @(posedge CLK);
    #2;
    RST = 1'b0;
    drive_nop();

    push_wb(RW'(5), 32'h1234);
    issue(OP_ADD, 32'h0, 32'h0, RW'(5), 1'b1, 32'h1234, st);
    check("add_stalls", st, 0);

    ack_delay = 0; rdata_val = 32'h80FFFFFF;
    push_bus(1'b0, 32'h100, 4'b1000, 32'h0);
    push_wb(RW'(6), 32'hFFFFFF80);
    issue(OP_LB, 32'h103, 32'h0, RW'(6), 1'b1, 32'h0, st);
    check("lb_stalls", st, 1);
    push_bus(1'b0, 32'h100, 4'b1000, 32'h0);
    push_wb(RW'(7), 32'h00000080);
    issue(OP_LBU, 32'h103, 32'h0, RW'(7), 1'b1, 32'h0, st);
    check("lbu_stalls", st, 1);
    push_bus(1'b0, 32'h100, 4'b1100, 32'h0);
    push_wb(RW'(8), 32'hFFFF80FF);
    issue(OP_LH, 32'h102, 32'h0, RW'(8), 1'b1, 32'h0, st);
    push_bus(1'b0, 32'h100, 4'b1100, 32'h0);
    push_wb(RW'(9), 32'h000080FF);
    issue(OP_LHU, 32'h102, 32'h0, RW'(9), 1'b1, 32'h0, st);

    ack_delay = 3;
    push_bus(1'b1, 32'h200, 4'b1100, 32'h12341234);
    issue(OP_SH, 32'h202, 32'hABCD1234, RW'(11), 1'b1, 32'h0, st);
    check("sh_stalls", st, 4);

    ack_delay = 0;
    push_bus(1'b1, 32'h0, 4'b0010, 32'hA5A5A5A5);
    issue(OP_SB, 32'h001, 32'h000000A5, RW'(12), 1'b1, 32'h0, st);

    rdata_val = 32'hDEADBEEF;
    rises0 = req_rises;
    push_bus(1'b0, 32'h400, 4'b1111, 32'h0);
    push_wb(RW'(10), 32'hDEADBEEF);
    issue(OP_LW, 32'h400, 32'h0, RW'(10), 1'b1, 32'h0, st);
    check("lw_stalls", st, 1);
    push_bus(1'b1, 32'h404, 4'b1111, 32'hCAFEF00D);
    issue(OP_SW, 32'h404, 32'hCAFEF00D, RW'(13), 1'b1, 32'h0, st);
    check("sw_stalls", st, 1);
    check("lw_sw_req_count", req_rises - rises0, 2);

    ack_delay = 100;
    AluOP_i = OP_LW; mem_addr_i = 32'h500; rd_i = RW'(3); rd_op_i = 1'b1;
    push_bus(1'b0, 32'h500, 4'b1111, 32'h0);
    @(negedge CLK);
    check("rstreq_stall_idle", stallreq, 1);
    @(posedge CLK);
    #2;
    @(negedge CLK);
    check("rstreq_req", dbus_req, 1);
    check("rstreq_stall_wait", stallreq, 1);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    @(negedge CLK);
    check("rstreq_stall_forced", stallreq, 0);
    @(posedge CLK);
    #2;
    RST = 1'b0;
    drive_nop();
    ack_delay = 0;
    void'(bus_q.pop_front());
    @(negedge CLK);
    check("rstreq_req_after", dbus_req, 0);
    check("rstreq_stall_after", stallreq, 0);
    check("rstreq_rd_op_o", rd_op_o, 0);
    check("rstreq_rd_o", rd_o, 0);
    check("rstreq_rd_data_o", rd_data_o, 0);
    check("rstreq_be", dbus_be, 0);
    @(posedge CLK);
    #2;
    push_wb(RW'(7), 32'h55);
    issue(OP_ADD, 32'h0, 32'h0, RW'(7), 1'b1, 32'h55, st);
    check("add2_stalls", st, 0);

    rdata_val = 32'h11223344;
    rises0 = req_rises;
`ifdef MEM_MISALIGN_TRAP_EN
    issue(OP_LW, 32'h301, 32'h0, RW'(14), 1'b1, 32'h0, st);
    check("mis_stalls", st, 0);
    @(negedge CLK);
    check("mis_pulse", misalign_o, 1);
    check("mis_rd_op_o", rd_op_o, 0);
    @(posedge CLK);
    #2;
    @(negedge CLK);
    check("mis_pulse_end", misalign_o, 0);
    check("mis_no_req", req_rises - rises0, 0);
`else
    push_bus(1'b0, 32'h300, 4'b1111, 32'h0);
    push_wb(RW'(14), 32'h11223344);
    issue(OP_LW, 32'h301, 32'h0, RW'(14), 1'b1, 32'h0, st);
    check("mis_stalls", st, 1);
    @(negedge CLK);
    check("mis_flag_tied", misalign_o, 0);
    check("mis_req_count", req_rises - rises0, 1);
`endif
    @(posedge CLK);
    #2;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("wb_queue_empty", wb_q.size(), 0);
    check("bus_queue_empty", bus_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
